// File: rtl/logic_unit_arbiter_if.sv
// Bundle of the two requester channels, the response channel and the busy flag
// for logic_unit_arbiter. The slave modport is the arbiter side; the master
// modport is the requester/consumer side.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 32
);
    // Requester 0 channel
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    // Requester 1 channel
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;

    // Status
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_r,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_r,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR).
// A three-state FSM grants one request in IDLE, computes it in EXEC and holds
// the registered result in RESP until the consumer takes it. Contention is
// resolved by a round-robin pointer that flips to the other requester after
// every served response.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_unit_arbiter_if.slave   bus
);

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcode encoding shared by both requesters
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Requester channels gathered into arrays indexed by requester id
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][1:0]       req_op;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;

    // FSM and arbitration
    state_t                        state_reg;
    state_t                        state_next;
    logic                          prio_reg;
    logic                          prio_next;
    logic                          grant_fire;
    logic                          grant_id;

    // Captured operation
    logic [1:0]                    op_reg;
    logic [WIDTH-1:0]              a_reg;
    logic [WIDTH-1:0]              b_reg;
    logic                          id_reg;

    // Logic unit and response registers
    logic [WIDTH-1:0]              alu_result;
    logic [WIDTH-1:0]              rsp_r_reg;
    logic                          rsp_valid_reg;
    logic                          busy_reg;

    assign req_valid[0] = bus.req0_valid;
    assign req_op[0]    = bus.req0_op;
    assign req_a[0]     = bus.req0_a;
    assign req_b[0]     = bus.req0_b;
    assign req_valid[1] = bus.req1_valid;
    assign req_op[1]    = bus.req1_op;
    assign req_a[1]     = bus.req1_a;
    assign req_b[1]     = bus.req1_b;

    // Readies are forced low while reset is held so nothing looks accepted
    // before the block is alive.
    assign bus.req0_ready = req_ready[0] & rst_n;
    assign bus.req1_ready = req_ready[1] & rst_n;

    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = id_reg;
    assign bus.rsp_r      = rsp_r_reg;
    assign bus.busy       = busy_reg;

    // Next-state, grant selection and ready decode
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        grant_fire = 1'b0;
        grant_id   = 1'b0;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_fire = 1'b1;
                    // Round-robin pointer only matters when both are pending.
                    grant_id   = (&req_valid) ? prio_reg : req_valid[1];
                    req_ready[grant_id] = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                    prio_next  = ~id_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-bit logic unit on the captured operands; no carries or flags
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alu_bit
            logic bit_a;
            logic bit_b;
            assign bit_a = a_reg[gi];
            assign bit_b = b_reg[gi];
            assign alu_result[gi] =
                (op_reg == OP_AND) ? (bit_a & bit_b) :
                (op_reg == OP_OR)  ? (bit_a | bit_b) :
                (op_reg == OP_XOR) ? (bit_a ^ bit_b) :
                                     ~(bit_a | bit_b);
        end
    endgenerate

    // State and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
        end
    end

    // Capture the granted request so the requester may drop or change it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= OP_AND;
            a_reg  <= '0;
            b_reg  <= '0;
            id_reg <= 1'b0;
        end else if (grant_fire) begin
            op_reg <= req_op[grant_id];
            a_reg  <= req_a[grant_id];
            b_reg  <= req_b[grant_id];
            id_reg <= grant_id;
        end
    end

    // Register the result once in EXEC; it then holds through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r_reg <= '0;
        end else if (state_reg == EXEC) begin
            rsp_r_reg <= alu_result;
        end
    end

    // Status outputs come straight from flops, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rsp_valid_reg <= (state_next == RESP);
            busy_reg      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a vector table of single operations
// plus hand-written sequences for contention, backpressure, reset abort and
// single-requester back-to-back traffic.
module tb_logic_unit_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(W)) bus ();

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         id;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    task automatic drive_req(input logic id, input logic valid, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = valid; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = valid; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full operation from an idle FSM with rsp_ready held high
    task automatic run_vec(input vec_t v, input int idx);
        logic own_ready;
        logic oth_ready;
        @(posedge clk); #1;
        drive_req(v.id, 1'b1, v.op, v.a, v.b);
        @(negedge clk);
        own_ready = v.id ? bus.req1_ready : bus.req0_ready;
        oth_ready = v.id ? bus.req0_ready : bus.req1_ready;
        chk($sformatf("vec%0d grant ready", idx), own_ready, 1);
        chk($sformatf("vec%0d other ready", idx), oth_ready, 0);
        @(posedge clk); #1;
        // Drop valid and scramble operands: the in-flight op must be unaffected
        drive_req(v.id, 1'b0, ~v.op, ~v.a, ~v.b);
        @(negedge clk);
        chk($sformatf("vec%0d exec busy", idx), bus.busy, 1);
        chk($sformatf("vec%0d exec rsp_valid", idx), bus.rsp_valid, 0);
        @(negedge clk);
        chk($sformatf("vec%0d rsp_valid", idx), bus.rsp_valid, 1);
        chk($sformatf("vec%0d rsp_r", idx), bus.rsp_r, v.exp_r);
        chk($sformatf("vec%0d rsp_id", idx), bus.rsp_id, v.id);
        $display("vec %0d: id=%0d op=%0d a=%h b=%h r=%h", idx, v.id, v.op, v.a, v.b, bus.rsp_r);
        @(negedge clk);
        chk($sformatf("vec%0d retired rsp_valid", idx), bus.rsp_valid, 0);
        chk($sformatf("vec%0d retired busy", idx), bus.busy, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
        vecs[1] = '{1'b0, 2'b00, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505};
        vecs[2] = '{1'b1, 2'b01, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF};
        vecs[3] = '{1'b0, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA};
        vecs[4] = '{1'b1, 2'b11, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h50505050};
        vecs[5] = '{1'b1, 2'b10, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987};
        vecs[6] = '{1'b0, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[7] = '{1'b0, 2'b01, 32'h80000001, 32'h00000000, 32'h80000001};

        idle_inputs();
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state, including a valid request held during reset
        repeat (2) @(posedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset rsp_id", bus.rsp_id, 0);
        chk("reset rsp_r", bus.rsp_r, 0);
        chk("reset req0_ready", bus.req0_ready, 0);
        chk("reset req1_ready", bus.req1_ready, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle no-valid req0_ready", bus.req0_ready, 0);
        chk("idle no-valid req1_ready", bus.req1_ready, 0);

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Contention right after reset: grants 0,1,0,1 spaced 3 cycles
        do_reset();
        begin
            int  n_grants;
            int  n_rsp;
            int  last_grant;
            logic exp_id;
            logic [W-1:0] exp_r;
            n_grants   = 0;
            n_rsp      = 0;
            last_grant = 0;
            @(posedge clk); #1;
            drive_req(1'b0, 1'b1, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
            drive_req(1'b1, 1'b1, 2'b10, 32'h0000FFFF, 32'hFFFFFFFF);
            for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    exp_id = n_grants[0];
                    chk($sformatf("contention grant%0d req0_ready", n_grants), bus.req0_ready, !exp_id);
                    chk($sformatf("contention grant%0d req1_ready", n_grants), bus.req1_ready, exp_id);
                    if (n_grants > 0)
                        chk($sformatf("contention grant%0d spacing", n_grants), cyc - last_grant, 3);
                    last_grant = cyc;
                    n_grants++;
                end
                if (bus.rsp_valid) begin
                    exp_id = n_rsp[0];
                    exp_r  = exp_id ? 32'hFFFF0000 : 32'hF000F000;
                    chk($sformatf("contention rsp%0d rsp_id", n_rsp), bus.rsp_id, exp_id);
                    chk($sformatf("contention rsp%0d rsp_r", n_rsp), bus.rsp_r, exp_r);
                    $display("contention rsp %0d: id=%0d r=%h", n_rsp, bus.rsp_id, bus.rsp_r);
                    n_rsp++;
                end
            end
            chk("contention response count", n_rsp, 4);
            chk("contention grant count", n_grants, 4);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
        end

        // Backpressure: hold RESP for 5 cycles with req0 pending
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 1'b1, 2'b11, 32'h0000000F, 32'h000000F0);
        @(negedge clk);
        chk("bp grant req1_ready", bus.req1_ready, 1);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        drive_req(1'b0, 1'b1, 2'b01, 32'h11110000, 32'h00002222);
        @(negedge clk);
        chk("bp exec req0_ready", bus.req0_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d rsp_valid", k), bus.rsp_valid, 1);
            chk($sformatf("bp hold%0d rsp_r", k), bus.rsp_r, 32'hFFFFFF00);
            chk($sformatf("bp hold%0d rsp_id", k), bus.rsp_id, 1);
            chk($sformatf("bp hold%0d readies", k), {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp accept rsp_valid", bus.rsp_valid, 1);
        chk("bp accept rsp_r", bus.rsp_r, 32'hFFFFFF00);
        $display("backpressure rsp: id=%0d r=%h", bus.rsp_id, bus.rsp_r);
        @(negedge clk);
        chk("bp after rsp_valid", bus.rsp_valid, 0);
        chk("bp after req0_ready", bus.req0_ready, 1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("bp follow rsp_valid", bus.rsp_valid, 1);
        chk("bp follow rsp_r", bus.rsp_r, 32'h11112222);
        chk("bp follow rsp_id", bus.rsp_id, 0);
        $display("backpressure follow rsp: id=%0d r=%h", bus.rsp_id, bus.rsp_r);
        @(negedge clk);

        // Reset asserted during EXEC aborts the operation
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h12345678);
        @(posedge clk); #1;
        idle_inputs();
        chk("abort pre busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort rsp_valid", bus.rsp_valid, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort rsp_id", bus.rsp_id, 0);
        chk("abort rsp_r", bus.rsp_r, 0);
        chk("abort readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
        $display("reset abort: rsp_valid=%0d busy=%0d r=%h", bus.rsp_valid, bus.busy, bus.rsp_r);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort post%0d rsp_valid", k), bus.rsp_valid, 0);
            chk($sformatf("abort post%0d busy", k), bus.busy, 0);
        end

        // Only req1 valid, back-to-back: every grant to req1
        begin
            int n_rsp;
            int n_grants;
            n_rsp    = 0;
            n_grants = 0;
            @(posedge clk); #1;
            drive_req(1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'hFFFF0000);
            for (int cyc = 0; cyc < 30 && n_rsp < 3; cyc++) begin
                @(negedge clk);
                if (bus.req0_ready) chk("starve req0_ready", bus.req0_ready, 0);
                if (bus.req1_ready) n_grants++;
                if (bus.rsp_valid) begin
                    chk($sformatf("starve rsp%0d rsp_id", n_rsp), bus.rsp_id, 1);
                    chk($sformatf("starve rsp%0d rsp_r", n_rsp), bus.rsp_r, 32'hDEAD0000);
                    $display("starve rsp %0d: id=%0d r=%h", n_rsp, bus.rsp_id, bus.rsp_r);
                    n_rsp++;
                end
            end
            chk("starve response count", n_rsp, 3);
            chk("starve grant count", n_grants, 3);
            @(posedge clk); #1;
            idle_inputs();
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
